trace_stream_out: RTL and testbench
===================================

TRACE_STREAM_OUT -- requirements
Module: trace_stream_out

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of buffered trace records; power of two, minimum 2.
REQ-002 SHALL have parameter DROP_CNT_WIDTH, default 16, the width of the dropped-record counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port trace_data_i  input  128  trace record from the tracer's trace_data_o.
REQ-006 SHALL have port trace_capture_enable_i  input  1  one-cycle strobe; record valid this cycle.
REQ-007 SHALL have port counter_i  input  32  tracer cycle counter, sampled as the record timestamp.
REQ-008 SHALL have port m_tdata  output  32  stream data word.
REQ-009 SHALL have port m_tvalid  output  1  stream word valid.
REQ-010 SHALL have port m_tready  input  1  downstream accepts the word.
REQ-011 SHALL have port m_tlast  output  1  marks the final word of a record.
REQ-012 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  number of records held, including the one being sent.
REQ-013 SHALL have port dropped_count  output  DROP_CNT_WIDTH  number of records lost to overflow.

Function
REQ-014 SHALL store, per capture, a 160-bit entry {counter_i, trace_data_i} sampled in the strobe cycle.
REQ-015 SHALL accept a capture only when fifo_level < FIFO_DEPTH, using the registered level before any same-cycle pop.
REQ-016 SHALL drop a capture arriving when full (even if the head record completes in that cycle), and increment dropped_count.
REQ-017 SHALL saturate dropped_count at all-ones; it SHALL NOT wrap.
REQ-018 SHALL emit each record as 5 words, in order: W0 = timestamp, W1 = data[31:0], W2 = data[63:32], W3 = data[95:64], W4 = data[127:96].
REQ-019 SHALL assert m_tlast only with W4.
REQ-020 SHALL transfer a word only in a cycle with m_tvalid=1 and m_tready=1.
REQ-021 SHALL hold m_tdata and m_tlast stable, and keep m_tvalid high, while m_tvalid=1 and m_tready=0.
REQ-022 SHALL implement the FSM as follows:
- IDLE: m_tvalid=0; go to SEND with word_idx=0 when fifo_level>0.
- SEND: m_tvalid=1; on transfer with word_idx<4, increment word_idx.
- SEND, transfer with word_idx=4: pop the head; return to IDLE if the level after pop is 0, else stay in SEND with word_idx=0.
- Back-to-back records SHALL have no idle cycle between them.
REQ-023 SHALL give latency: capture in cycle N into an empty FIFO in IDLE -> W0 presented with m_tvalid=1 in cycle N+2.
- Cycle N+1 is the FIFO write / FSM transition cycle.
REQ-024 SHALL update fifo_level on the cycle after a push or pop; it SHALL be unchanged when a push and a pop occur in the same cycle.
REQ-025 SHALL use wrapping read/write pointers modulo FIFO_DEPTH; full and empty SHALL be distinguished by fifo_level.
REQ-026 SHALL accept trace_capture_enable_i on consecutive cycles while space remains.
REQ-027 SHALL keep m_tdata at 0 when m_tvalid=0.

Reset
REQ-028 SHALL, when rst_n=0 at a clock edge, set FSM=IDLE, word_idx=0, pointers=0, fifo_level=0, dropped_count=0, m_tvalid=0, m_tlast=0 and m_tdata=0.
REQ-029 SHALL have reset dominate all other inputs; captures during reset SHALL be ignored and SHALL NOT count as dropped.
REQ-030 SHALL discard any partly sent record on reset mid-operation; after reset, no remaining words of it SHALL appear.

Verification
REQ-031 SHALL cover single record: counter_i=0x00000010, data=0x33..33_22..22_11..11_00..00, strobe once, m_tready=1 -> 0x10, 0x00000000, 0x11111111, 0x22222222, 0x33333333 on consecutive cycles; m_tlast only on the last; first word 2 cycles after the strobe.
REQ-032 SHALL cover backpressure: m_tready=0 for 3 cycles during W2 -> W2 held stable with m_tvalid=1, then W3 and W4 follow with no loss.
REQ-033 SHALL cover overflow: FIFO_DEPTH=4, m_tready=0, 6 strobes -> fifo_level=4, dropped_count=2; releasing m_tready yields exactly 4 records, in capture order.
REQ-034 SHALL cover full plus pop: FIFO full and W4 transferring in the same cycle as a strobe -> capture dropped, dropped_count+1, fifo_level=3 next cycle.
REQ-035 SHALL cover saturation: force more than 65535 drops -> dropped_count stays at 0xFFFF.
REQ-036 SHALL cover reset mid-record: rst_n=0 for 1 cycle after W1 -> next cycle m_tvalid=0, fifo_level=0, dropped_count=0; a new strobe then yields a clean W0.

Source files
------------

// File: rtl/trace_stream_out.sv
// trace_stream_out: buffers {timestamp, 128-bit data} trace records and streams
// each one out as five 32-bit AXI-Stream words, counting records lost to overflow.
module trace_stream_out #(
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [127:0]                  trace_data_i,
  input  logic                          trace_capture_enable_i,
  input  logic [31:0]                   counter_i,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_CNT_WIDTH-1:0]     dropped_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                    r_state, w_state_nx;
  logic [159:0]              r_mem [FIFO_DEPTH];
  logic [AW-1:0]             r_wptr, r_rptr;
  logic [AW:0]               r_level, w_level_nx;
  logic [2:0]                r_idx, w_idx_nx;
  logic [DROP_CNT_WIDTH-1:0] r_drop;
  logic                      w_full, w_push, w_pop;
  logic [159:0]              w_head;
  // Fullness uses the registered level, so a same-cycle pop never frees room for a capture.
  assign w_full     = r_level == (AW+1)'(FIFO_DEPTH);
  assign w_push     = trace_capture_enable_i && !w_full;
  assign w_pop      = r_state == SEND && m_tready && r_idx == 3'd4;
  assign w_level_nx = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_head     = r_mem[r_rptr];
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    if (r_state == IDLE) begin
      w_idx_nx = '0;
      if (r_level != '0) w_state_nx = SEND;
    end else if (m_tready) begin
      w_idx_nx = w_pop ? 3'd0 : r_idx + 3'd1;
      if (w_pop && w_level_nx == '0) w_state_nx = IDLE;
    end
  end
  assign m_tvalid = r_state == SEND;
  assign m_tlast  = m_tvalid && r_idx == 3'd4;
  assign m_tdata  = !m_tvalid     ? 32'd0 :
                    r_idx == 3'd0 ? w_head[159:128] :
                    r_idx == 3'd1 ? w_head[31:0] :
                    r_idx == 3'd2 ? w_head[63:32] :
                    r_idx == 3'd3 ? w_head[95:64] : w_head[127:96];
  assign fifo_level    = r_level;
  assign dropped_count = r_drop;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_level <= w_level_nx;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (trace_capture_enable_i && w_full && r_drop != '1) r_drop <= r_drop + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wptr] <= {counter_i, trace_data_i};
  end
endmodule

// File: tb/tb_trace_stream_out.sv
// tb_trace_stream_out: directed and random stimulus against a record-queue model
// of the trace streamer (timestamp + 4 data words per record, saturating drop count).
module tb_trace_stream_out;
  localparam int DEPTH = 4;
  logic         clk = 1'b0;
  logic         rst_n, en, tready;
  logic [31:0]  cnt;
  logic [127:0] data;
  logic [31:0]  m_tdata;
  logic         m_tvalid, m_tlast;
  logic [2:0]   fifo_level;
  logic [15:0]  dropped_count;
  int total = 0, bad = 0;
  logic [159:0] q[$];
  int widx = 0, m_drop = 0, recs_out = 0;
  bit prev_ne = 0;
  trace_stream_out #(.FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .trace_data_i(data), .trace_capture_enable_i(en),
    .counter_i(cnt), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(tready),
    .m_tlast(m_tlast), .fifo_level(fifo_level), .dropped_count(dropped_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] word(logic [159:0] r, int i);
    return i == 0 ? r[159:128] : r[32*(i-1) +: 32];
  endfunction
  // One clock: check outputs mid-cycle against the model, advance the model, then step past the edge.
  task automatic tick();
    bit ev, acc;
    @(negedge clk);
    ev = prev_ne && q.size() > 0;
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("dropped", 32'(dropped_count), 32'(m_drop));
    chk("valid", 32'(m_tvalid), 32'(ev));
    chk("data", m_tdata, ev ? word(q[0], widx) : 32'd0);
    chk("last", 32'(m_tlast), 32'(ev && widx == 4));
    prev_ne = q.size() > 0;
    if (!rst_n) begin
      q.delete();
      widx = 0;
      m_drop = 0;
      prev_ne = 0;
    end else begin
      acc = en && q.size() < DEPTH;
      if (ev && tready) begin
        if (widx == 4) begin
          void'(q.pop_front());
          widx = 0;
          recs_out++;
        end else widx++;
      end
      if (en) begin
        if (acc) q.push_back({cnt, data});
        else if (m_drop < 65535) m_drop++;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic strobe(logic [31:0] c, logic [127:0] d);
    cnt = c;
    data = d;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic drain();
    tready = 1'b1;
    for (int i = 0; i < 300 && q.size() > 0; i++) tick();
    tick();
    chk("drain_level", 32'(fifo_level), 32'd0);
  endtask
  initial begin
    logic [127:0] d;
    int r0, n;
    rst_n = 1'b0; en = 1'b0; tready = 1'b1; cnt = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_tvalid), 32'd0);
    chk("rst_data", m_tdata, 32'd0);
    chk("rst_last", 32'(m_tlast), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_dropped", 32'(dropped_count), 32'd0);
    // strobes during reset are neither stored nor counted as drops
    en = 1'b1;
    tick();
    en = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rst_strobe_level", 32'(fifo_level), 32'd0);
    chk("rst_strobe_drop", 32'(dropped_count), 32'd0);
    // single record, full-rate
    strobe(32'h10, {{4{8'h33}}, {4{8'h22}}, {4{8'h11}}, 32'h0});
    chk("lat_n1_valid", 32'(m_tvalid), 32'd0);
    tick();
    chk("w0_valid", 32'(m_tvalid), 32'd1);
    chk("w0", m_tdata, 32'h10);
    tick(); chk("w1", m_tdata, 32'h0);
    tick(); chk("w2", m_tdata, 32'h11111111);
    tick(); chk("w3", m_tdata, 32'h22222222);
    chk("w3_last", 32'(m_tlast), 32'd0);
    tick(); chk("w4", m_tdata, 32'h33333333);
    chk("w4_last", 32'(m_tlast), 32'd1);
    tick(); chk("post_idle", 32'(m_tvalid), 32'd0);
    // backpressure during W2
    d = rnd128();
    strobe(32'hA5, d);
    tick(); tick(); tick();
    tready = 1'b0;
    chk("bp_w2", m_tdata, d[63:32]);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", 32'(m_tvalid), 32'd1);
      chk("bp_hold_data", m_tdata, d[63:32]);
    end
    tready = 1'b1;
    tick(); chk("bp_w3", m_tdata, d[95:64]);
    tick(); chk("bp_w4", m_tdata, d[127:96]);
    chk("bp_w4_last", 32'(m_tlast), 32'd1);
    tick();
    // overflow: 6 strobes into a depth-4 FIFO with the sink stalled
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 6; i++) strobe(32'(100 + i), rnd128());
    tick();
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_dropped", 32'(dropped_count), 32'd2);
    r0 = recs_out;
    drain();
    chk("ovf_records", 32'(recs_out - r0), 32'd4);
    // full FIFO with W4 completing in the same cycle as a strobe
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(32'(200 + i), rnd128());
    tready = 1'b1;
    n = 0;
    while (!(m_tvalid && m_tlast) && n < 30) begin
      tick();
      n++;
    end
    chk("fp_reach_w4", 32'(n < 30), 32'd1);
    strobe(32'h300, rnd128());
    chk("fp_level", 32'(fifo_level), 32'd3);
    chk("fp_dropped", 32'(dropped_count), 32'd1);
    drain();
    // reset in the middle of a record
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 5; i++) strobe(32'(400 + i), rnd128());
    tready = 1'b1;
    n = 0;
    while (!m_tvalid && n < 10) begin
      tick();
      n++;
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_dropped", 32'(dropped_count), 32'd0);
    tick(); tick();
    chk("mid_rst_quiet", 32'(m_tvalid), 32'd0);
    strobe(32'hBEEF, rnd128());
    tick();
    chk("mid_rst_new_w0", m_tdata, 32'hBEEF);
    drain();
    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 2) == 0;
      tready = $urandom_range(0, 3) != 0;
      cnt = $urandom;
      data = rnd128();
      tick();
    end
    en = 1'b0;
    drain();
    // drop counter saturation
    do_reset();
    tready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 65545; i++) begin
      cnt = i;
      tick();
    end
    en = 1'b0;
    chk("sat_dropped", 32'(dropped_count), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(dropped_count), 32'hFFFF);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
